// File: rtl/io_pkg.sv
// io_pkg: shared widths, nibble type and FSM state encodings for the
// RLE word packer (optional stats port macro: PACKER_STATS_EN).
package io_pkg;

    localparam int WORD_W      = 32;
    localparam int NIBBLE_W    = 4;
    localparam int NIBBLES_DEF = 8;
    localparam int MAX_RUN_DEF = 7;

    typedef struct packed {
        logic       b;
        logic [2:0] run;
    } nibble_t;

    typedef enum logic [1:0] {
        O_IDLE  = 2'd0,
        O_WAIT  = 2'd1,
        O_GAP   = 2'd2,
        O_START = 2'd3
    } out_state_t;

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } in_state_t;

    // Slot 0 lands in [31:28]; later slots move toward the LSBs.
    function automatic logic [WORD_W-1:0] place_nibble(
        input nibble_t    n,
        input logic [2:0] slot
    );
        logic [WORD_W-1:0] w;
        w = {n, {(WORD_W-NIBBLE_W){1'b0}}} >> {slot, 2'b00};
        return w;
    endfunction

endpackage

// File: rtl/rle_run_encoder.sv
// rle_run_encoder: turns accepted serial bits into {bit, run} nibbles,
// at most one nibble per accepted bit; flush emits the open run.
module rle_run_encoder
    import io_pkg::*;
#(
    parameter int MAX_RUN = MAX_RUN_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_valid,
    input  logic    i_bit,
    input  logic    i_flush,
    output logic    o_nib_valid,
    output nibble_t o_nib
);

    localparam logic [2:0] LP_MAX = 3'(MAX_RUN);

    logic       r_cur_bit;
    logic [2:0] r_run_len;
    logic       w_has_run;
    logic       w_extend;

    assign w_has_run = (r_run_len != 3'd0);
    assign w_extend  = w_has_run
                    && (i_bit == r_cur_bit)
                    && (r_run_len < LP_MAX);

    assign o_nib_valid = (i_valid && w_has_run && !w_extend)
                      || (i_flush && w_has_run);
    assign o_nib       = {r_cur_bit, r_run_len};

    // Track the open run; a new bit either extends it or starts a new one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cur_bit <= 1'b0;
            r_run_len <= 3'd0;
        end else if (i_valid) begin
            if (w_extend) begin
                r_run_len <= r_run_len + 3'd1;
            end else begin
                r_cur_bit <= i_bit;
                r_run_len <= 3'd1;
            end
        end else if (i_flush) begin
            r_run_len <= 3'd0;
        end
    end

endmodule

// File: rtl/rle_word_packer.sv
// rle_word_packer: packs RLE nibbles into 32-bit words and hands them to
// the IO loader; PACKER_STATS_EN adds word_count/bit_count outputs.
module rle_word_packer
    import io_pkg::*;
#(
    parameter int MAX_RUN = MAX_RUN_DEF,
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_last,
    output logic              in_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              data_oe,
    output logic              interrupt,
    output logic              load_process,
    input  logic              done_cpu
`ifdef PACKER_STATS_EN
    ,
    output logic [15:0]       word_count,
    output logic [15:0]       bit_count
`endif
);

    localparam logic [3:0] LP_FULL = 4'(NIBBLES);

    in_state_t         r_istate;
    out_state_t        r_ostate;
    logic [WORD_W-1:0] r_pack;
    logic [3:0]        r_pack_cnt;
    logic              r_pack_final;
    logic              r_flushed;
    logic [WORD_W-1:0] r_ob_data;
    logic              r_ob_valid;
    logic              r_ob_final;
    logic              r_acked_final;
    logic              r_load;

    logic              w_fire;
    logic              w_flush;
    logic              w_nib_valid;
    nibble_t           w_nib;
    logic [WORD_W-1:0] w_pack_nx;
    logic [3:0]        w_cnt_nx;
    logic              w_fin_nx;
    logic              w_full_nx;
    logic              w_ob_free;
    logic              w_commit;

    assign in_ready = rst
                   && (r_istate == PACK)
                   && (r_pack_cnt < LP_FULL);
    assign w_fire   = in_valid && in_ready;
    assign w_flush  = (r_istate == FLUSH)
                   && !r_flushed
                   && (r_pack_cnt < LP_FULL);

    rle_run_encoder #(
        .MAX_RUN (MAX_RUN)
    ) u_enc (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_fire),
        .i_bit       (in_bit),
        .i_flush     (w_flush),
        .o_nib_valid (w_nib_valid),
        .o_nib       (w_nib)
    );

    // Next pack contents; the flush pads with zero nibbles (decode to nothing).
    always_comb begin
        w_pack_nx = r_pack;
        w_cnt_nx  = r_pack_cnt;
        if (w_nib_valid) begin
            w_pack_nx = r_pack | place_nibble(w_nib, r_pack_cnt[2:0]);
            w_cnt_nx  = r_pack_cnt + 4'd1;
        end
        w_fin_nx = r_pack_final || w_flush;
        if (w_flush && (w_cnt_nx != 4'd0)) begin
            w_cnt_nx = LP_FULL;
        end
        w_full_nx = (w_cnt_nx == LP_FULL);
    end

    assign w_ob_free = (r_ostate == O_WAIT) && done_cpu;
    assign w_commit  = w_full_nx && (!r_ob_valid || w_ob_free);

    // Pack register: accumulate nibbles, empty when the word is committed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pack       <= '0;
            r_pack_cnt   <= 4'd0;
            r_pack_final <= 1'b0;
        end else if (w_commit) begin
            r_pack       <= '0;
            r_pack_cnt   <= 4'd0;
            r_pack_final <= 1'b0;
        end else begin
            r_pack       <= w_pack_nx;
            r_pack_cnt   <= w_cnt_nx;
            r_pack_final <= w_fin_nx;
        end
    end

    // Out buffer: loaded from a full pack, freed when the IO acks it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ob_data  <= '0;
            r_ob_valid <= 1'b0;
            r_ob_final <= 1'b0;
        end else if (w_commit) begin
            r_ob_data  <= w_pack_nx;
            r_ob_valid <= 1'b1;
            r_ob_final <= w_fin_nx;
        end else if (w_ob_free) begin
            r_ob_valid <= 1'b0;
        end
    end

    // Input side: accept bits until the last one, then flush once and
    // stay closed until the start indication has been issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_istate  <= PACK;
            r_flushed <= 1'b0;
        end else begin
            unique case (r_istate)
                PACK: begin
                    if (w_fire && in_last) begin
                        r_istate <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (r_ostate == O_START) begin
                        r_istate  <= PACK;
                        r_flushed <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Out handshake FSM: present, wait for done_cpu, gap, then next or start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ostate      <= O_IDLE;
            r_acked_final <= 1'b0;
            r_load        <= 1'b0;
        end else begin
            unique case (r_ostate)
                O_IDLE: begin
                    if (r_ob_valid) begin
                        r_ostate <= O_WAIT;
                        r_load   <= 1'b1;
                    end
                end
                O_WAIT: begin
                    if (done_cpu) begin
                        r_ostate      <= O_GAP;
                        r_acked_final <= r_ob_final;
                    end
                end
                O_GAP: begin
                    if (r_acked_final) begin
                        r_ostate <= O_START;
                        r_load   <= 1'b0;
                    end else if (r_ob_valid) begin
                        r_ostate <= O_WAIT;
                    end else begin
                        r_ostate <= O_IDLE;
                    end
                end
                O_START: begin
                    r_ostate      <= O_IDLE;
                    r_acked_final <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt    = (r_ostate == O_WAIT) || (r_ostate == O_START);
    assign data_oe      = (r_ostate == O_WAIT);
    assign data_out     = (r_ostate == O_WAIT) ? r_ob_data : '0;
    assign load_process = r_load;

`ifdef PACKER_STATS_EN
    logic [15:0] r_word_cnt;
    logic [15:0] r_bit_cnt;

    // Saturating counters of acked words and accepted bits per load.
    always_ff @(posedge clk) begin
        if (!rst || (r_ostate == O_START)) begin
            r_word_cnt <= 16'd0;
            r_bit_cnt  <= 16'd0;
        end else begin
            if (w_ob_free && (r_word_cnt != 16'hFFFF)) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
            if (w_fire && (r_bit_cnt != 16'hFFFF)) begin
                r_bit_cnt <= r_bit_cnt + 16'd1;
            end
        end
    end

    assign word_count = r_word_cnt;
    assign bit_count  = r_bit_cnt;
`endif

endmodule

// File: tb/tb_rle_word_packer.sv
// tb_rle_word_packer: directed tests for the RLE word packer handshake.
// Expected words are hand-encoded from the nibble format {bit, run}.
module tb_rle_word_packer;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit   = 1'b0;
    logic        in_last  = 1'b0;
    logic        done_cpu = 1'b0;
    logic        in_ready;
    logic [31:0] data_out;
    logic        data_oe;
    logic        interrupt;
    logic        load_process;
`ifdef PACKER_STATS_EN
    logic [15:0] word_count;
    logic [15:0] bit_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rle_word_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .interrupt    (interrupt),
        .load_process (load_process),
        .done_cpu     (done_cpu)
`ifdef PACKER_STATS_EN
        ,
        .word_count   (word_count),
        .bit_count    (bit_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer bits [first, stop) of a stream of length total; returns next index.
    task automatic drive(input bit alt, input bit val, input int first,
                         input int stop, input int total, input int max_cyc,
                         output int next);
        int   i;
        logic rdy;
        i = first;
        for (int c = 0; c < max_cyc && i < stop; c++) begin
            in_valid = 1'b1;
            in_bit   = alt ? i[0] : val;
            in_last  = (i == total - 1);
            rdy      = in_ready;
            step();
            if (rdy) i++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bit   = 1'b0;
        next     = i;
    endtask

    // Wait for a presented word, capture it, then pulse done_cpu.
    task automatic ack_word(output logic [31:0] w, output logic lp,
                            output int waited);
        waited = 0;
        while (!(interrupt && data_oe) && waited < 300) begin
            step();
            waited++;
        end
        if (!(interrupt && data_oe)) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: interrupt=%b data_oe=%b required 1 1",
                     interrupt, data_oe);
            w  = '0;
            lp = 1'b0;
        end else begin
            w        = data_out;
            lp       = load_process;
            done_cpu = 1'b1;
            step();
            done_cpu = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({in_ready, data_oe, interrupt, load_process} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: rdy/oe/int/lp=%b required 0000",
                     {in_ready, data_oe, interrupt, load_process});
        end
        checks++;
        if (data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: data_out=%h required 0", data_out);
        end
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_one_word();
        int          n, wt;
        logic [31:0] w;
        logic        lp;
        drive(1'b0, 1'b1, 0, 8, 8, 50, n);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL t1_bits: accepted=%0d required 8", n);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL t1_flush_ready: in_ready=%b required 0", in_ready);
        end
        ack_word(w, lp, wt);
        checks++;
        if (w !== 32'hF9000000) begin
            failures++;
            $display("FAIL t1_word: data_out=%h required F9000000", w);
        end
        checks++;
        if (lp !== 1'b1) begin
            failures++;
            $display("FAIL t1_lp: load_process=%b required 1", lp);
        end
        checks++;
        if ({interrupt, load_process, data_oe} !== 3'b010) begin
            failures++;
            $display("FAIL t1_gap: int/lp/oe=%b required 010",
                     {interrupt, load_process, data_oe});
        end
        step();
        checks++;
        if ({load_process, interrupt, data_oe, in_ready} !== 4'b0100) begin
            failures++;
            $display("FAIL t1_start: lp/int/oe/rdy=%b required 0100",
                     {load_process, interrupt, data_oe, in_ready});
        end
        step();
        checks++;
        if ({load_process, interrupt, data_oe, in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL t1_idle: lp/int/oe/rdy=%b required 0001",
                     {load_process, interrupt, data_oe, in_ready});
        end
    endtask

    task automatic test_two_words();
        int          n, wt;
        logic [31:0] w;
        logic        lp;
        drive(1'b1, 1'b0, 0, 16, 16, 100, n);
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL t2_bits: accepted=%0d required 16", n);
        end
        ack_word(w, lp, wt);
        checks++;
        if (w !== 32'h19191919) begin
            failures++;
            $display("FAIL t2_word0: data_out=%h required 19191919", w);
        end
        checks++;
        if ({interrupt, load_process} !== 2'b01) begin
            failures++;
            $display("FAIL t2_gap: int/lp=%b required 01",
                     {interrupt, load_process});
        end
        ack_word(w, lp, wt);
        checks++;
        if (w !== 32'h19191919) begin
            failures++;
            $display("FAIL t2_word1: data_out=%h required 19191919", w);
        end
        checks++;
        if (wt !== 1) begin
            failures++;
            $display("FAIL t2_gap_len: gap=%0d required 1", wt);
        end
`ifdef PACKER_STATS_EN
        checks++;
        if (word_count !== 16'd2 || bit_count !== 16'd16) begin
            failures++;
            $display("FAIL t2_stats: words=%0d bits=%0d required 2 16",
                     word_count, bit_count);
        end
`endif
        step();
        checks++;
        if ({load_process, interrupt, data_oe} !== 3'b010) begin
            failures++;
            $display("FAIL t2_start: lp/int/oe=%b required 010",
                     {load_process, interrupt, data_oe});
        end
        step();
    endtask

    task automatic test_single_bit();
        int          n, wt;
        logic [31:0] w;
        logic        lp;
        drive(1'b0, 1'b0, 0, 1, 1, 20, n);
        ack_word(w, lp, wt);
        checks++;
        if (w !== 32'h10000000) begin
            failures++;
            $display("FAIL t3_word: data_out=%h required 10000000", w);
        end
        step();
        checks++;
        if ({load_process, interrupt, data_oe} !== 3'b010) begin
            failures++;
            $display("FAIL t3_start: lp/int/oe=%b required 010",
                     {load_process, interrupt, data_oe});
        end
        step();
    endtask

    task automatic test_backpressure();
        int          n, n2, wt;
        logic [31:0] w;
        logic [31:0] ws [4];
        logic        lp;
        drive(1'b1, 1'b0, 0, 40, 40, 30, n);
        checks++;
        if (n !== 17) begin
            failures++;
            $display("FAIL bp_stall_at: accepted=%0d required 17", n);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_low: in_ready=%b required 0", in_ready);
        end
        ack_word(w, lp, wt);
        checks++;
        if (w !== 32'h19191919) begin
            failures++;
            $display("FAIL bp_word0: data_out=%h required 19191919", w);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_back: in_ready=%b required 1", in_ready);
        end
        fork
            drive(1'b1, 1'b0, 17, 40, 40, 600, n2);
            begin
                logic lpk;
                int   wk;
                for (int k = 0; k < 4; k++) ack_word(ws[k], lpk, wk);
            end
        join
        checks++;
        if (n2 !== 40) begin
            failures++;
            $display("FAIL bp_total: accepted=%0d required 40", n2);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ws[k] !== 32'h19191919) begin
                failures++;
                $display("FAIL bp_word%0d: data_out=%h required 19191919",
                         k + 1, ws[k]);
            end
        end
        step();
        checks++;
        if ({load_process, interrupt, data_oe} !== 3'b010) begin
            failures++;
            $display("FAIL bp_start: lp/int/oe=%b required 010",
                     {load_process, interrupt, data_oe});
        end
        step();
    endtask

    task automatic test_reset_mid();
        int          n, wt;
        logic [31:0] w;
        logic        lp;
        drive(1'b1, 1'b0, 0, 9, 100, 50, n);
        for (int c = 0; c < 10 && !interrupt; c++) step();
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("FAIL rm_wait: interrupt=%b required 1", interrupt);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({interrupt, load_process, data_oe} !== 3'b000
            || data_out !== 32'h0) begin
            failures++;
            $display("FAIL rm_drop: int/lp/oe=%b data=%h required 000 0",
                     {interrupt, load_process, data_oe}, data_out);
        end
        rst = 1'b1;
        step();
        drive(1'b0, 1'b1, 0, 8, 8, 50, n);
        ack_word(w, lp, wt);
        checks++;
        if (w !== 32'hF9000000) begin
            failures++;
            $display("FAIL rm_clean: data_out=%h required F9000000", w);
        end
        step();
        step();
        checks++;
        if ({interrupt, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rm_idle: int/rdy=%b required 01",
                     {interrupt, in_ready});
        end
    endtask

    task automatic test_done_ignored();
        int          n, wt;
        logic [31:0] w;
        logic        lp;
        done_cpu = 1'b1;
        repeat (3) step();
        done_cpu = 1'b0;
        checks++;
        if ({interrupt, load_process} !== 2'b00) begin
            failures++;
            $display("FAIL di_idle: int/lp=%b required 00",
                     {interrupt, load_process});
        end
        drive(1'b1, 1'b0, 0, 16, 16, 100, n);
        ack_word(w, lp, wt);
        done_cpu = 1'b1;
        step();
        done_cpu = 1'b0;
        checks++;
        if (interrupt !== 1'b1 || data_out !== 32'h19191919) begin
            failures++;
            $display("FAIL di_gap: int=%b data=%h required 1 19191919",
                     interrupt, data_out);
        end
        ack_word(w, lp, wt);
        checks++;
        if (w !== 32'h19191919) begin
            failures++;
            $display("FAIL di_word1: data_out=%h required 19191919", w);
        end
        step();
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_one_word();
        test_two_words();
        test_single_bit();
        test_backpressure();
        test_reset_mid();
        test_done_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
